multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV64 datapath (PC, IR, register file, ALU, data memory).
//  Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the per-cycle
//  datapath enables and mux selects. Waits on data-memory handshake; traps on illegal
//  opcode or memory timeout. Replaces single-cycle Control_Unit when datapath is multi-cycle.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM waiting for mem_ready before fault (>=1)
//  CNT_W        5   width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  opcode       in   7   instruction[6:0] from IR
//  zero         in   1   ALU zero flag
//  mem_ready    in   1   data memory done with current read/write
//  pc_write     out  1   load PC
//  ir_write     out  1   load IR
//  reg_write    out  1   register file write enable
//  mem_read     out  1   data memory read strobe
//  mem_write    out  1   data memory write strobe
//  alu_src_a    out  1   0=PC, 1=rs1
//  alu_src_b    out  2   00=rs2, 01=const 4, 10=imm, 11=imm<<1
//  alu_op       out  2   00=add, 01=sub, 10=R-type funct, 11=I-type funct
//  mem_to_reg   out  1   1=writeback from memory, 0=ALUOut
//  pc_src       out  1   0=ALU result (PC+4), 1=ALUOut (branch target)
//  state        out  3   current state encoding
//  fault        out  1   controller in TRAP
//  instret      out  64  retired instruction count (see CONFIGURATION)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5; 6,7 unreachable -> FETCH.
//  Outputs decoded from state reg + latched opcode; all outputs 0 while reset low.
//  Reset: async, state<=FETCH, opcode latch<=0, wait cnt<=0, instret<=0; mid-instr abort ok.
//  FETCH : ir_write=1 pc_write=1 pc_src=0 a=0 b=01 op=00 -> DECODE (1 cycle).
//  DECODE: latch opcode; a=0 b=11 op=00 (branch target to ALUOut).
//          opcode in {0110011,0010011,0000011,0100011,1100011} -> EXEC else -> TRAP.
//  EXEC  : R(0110011): a=1 b=00 op=10 -> WB.  I(0010011): a=1 b=10 op=11 -> WB.
//          ld/sd: a=1 b=10 op=00 -> MEM.
//          beq: a=1 b=00 op=01 pc_src=1 pc_write=zero -> FETCH (retires).
//  MEM   : ld: mem_read=1; sd: mem_write=1; strobe held until mem_ready sampled high.
//          mem_ready=1 -> sd: FETCH (retires), ld: WB; cnt cleared.
//          mem_ready=0: cnt++; cnt==MEM_TIMEOUT-1 without ready -> TRAP.
//          mem_ready=1 on the timeout cycle wins (completes, no fault).
//  WB    : reg_write=1, mem_to_reg=(ld) -> FETCH (retires).
//  TRAP  : all enables 0, fault=1; sticky until reset.
//  Latency: beq 3, sd 4+w, R/I 4, ld 5+w cycles (w = extra MEM wait cycles).
// CONFIGURATION
//  PERF_CNT_EN defined: instret is 64-bit counter, +1 on each retire, wraps 2^64-1 -> 0.
//  PERF_CNT_EN undefined: no counter flops; instret tied to 64'd0.
// TESTING
//  1 reset low mid-EXEC -> all outputs 0 immediately; after release state=0, ir_write=1.
//  2 add (0110011) -> states 0,1,2,4,0; reg_write=1 only in WB, alu_op=10 in EXEC.
//  3 ld, mem_ready low 3 cycles -> mem_read high 4 MEM cycles, WB mem_to_reg=1, 8 cycles.
//  4 beq zero=1 -> pc_write=1,pc_src=1 in EXEC; zero=0 -> pc_write=0; both back to FETCH.
//  5 opcode 1111111 -> TRAP after DECODE, fault=1, no enables until reset.
//  6 sd with mem_ready never high, MEM_TIMEOUT=16 -> TRAP after 16 MEM cycles;
//    PERF_CNT_EN: instret=3 after add,ld,beq; undefined: instret=0 throughout.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multi-cycle sequencer for the RV64 datapath (PC, IR, register file, ALU,
//   data memory). Each instruction walks FETCH/DECODE/EXEC/MEM/WB. The block
//   drives the per-cycle datapath enables and mux selects. It waits on the
//   data-memory handshake and traps on an illegal opcode or a memory timeout.
//
// Parameters
//   MEM_TIMEOUT : max MEM cycles waiting for mem_ready before fault (>=1)
//   CNT_W       : wait counter width, must hold MEM_TIMEOUT
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   opcode     in   instruction[6:0] from IR
//   zero       in   ALU zero flag
//   mem_ready  in   data memory finished current access
//   pc_write, ir_write, reg_write, mem_read, mem_write   out  enables/strobes
//   alu_src_a  out  0=PC 1=rs1
//   alu_src_b  out  00=rs2 01=4 10=imm 11=imm<<1
//   alu_op     out  00=add 01=sub 10=R funct 11=I funct
//   mem_to_reg out  1=writeback from memory
//   pc_src     out  0=ALU result, 1=ALUOut
//   state      out  current state encoding
//   fault      out  controller in TRAP
//   instret    out  retired instruction count
//
// Configuration
//   PERF_CNT_EN : when defined, instret is a free-running 64-bit retire
//                 counter; otherwise instret is tied to zero.

module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic [2:0]  state,
  output logic        fault,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The opcode is captured in DECODE so later states do not depend on IR
  // staying stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  // Next state and outputs. The whole decode is gated by reset so every
  // output reads zero while reset is held low, even though the state
  // register sits in FETCH.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    fault      = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_DECODE;
        end
        S_DECODE: begin
          // Branch target is computed speculatively into ALUOut here.
          alu_src_b = 2'b11;
          case (opcode)
            OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: state_d = S_EXEC;
            default:                          state_d = S_TRAP;
          endcase
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          case (op_q)
            OP_R: begin
              alu_op  = 2'b10;
              state_d = S_WB;
            end
            OP_I: begin
              alu_src_b = 2'b10;
              alu_op    = 2'b11;
              state_d   = S_WB;
            end
            OP_LD, OP_SD: begin
              alu_src_b = 2'b10;
              state_d   = S_MEM;
            end
            OP_BEQ: begin
              alu_op   = 2'b01;
              pc_src   = 1'b1;
              pc_write = zero;
              state_d  = S_FETCH;
            end
            default: state_d = S_TRAP;
          endcase
        end
        S_MEM: begin
          mem_read  = (op_q == OP_LD);
          mem_write = (op_q == OP_SD);
          // A ready on the last allowed cycle still completes the access.
          if (mem_ready) begin
            cnt_d   = '0;
            state_d = (op_q == OP_SD) ? S_FETCH : S_WB;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_TRAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LD);
          state_d    = S_FETCH;
        end
        S_TRAP: begin
          fault = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state = state_q;

`ifdef PERF_CNT_EN
  logic        retire;
  logic [63:0] instret_q;

  // An instruction retires on its last cycle: beq in EXEC, sd on its MEM
  // completion, everything else in WB.
  assign retire = (state_q == S_WB) ||
                  (state_q == S_EXEC && op_q == OP_BEQ) ||
                  (state_q == S_MEM && op_q == OP_SD && mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule
